// File: rtl/pdt_resolve_pkg.sv
// Shared constants, resolve classification and entry sizing for the prediction tracking path.
// Entry layout, MSB first: {pc, pdt_res, target, which, history}.
package pdt_resolve_pkg;

    localparam int         ADDR_W_DEF = 32;
    localparam int         HIST_W_DEF = 10;
    localparam int         PC_STEP    = 4;
    localparam logic [6:0] BR_OPCODE  = 7'b1100011;

    typedef enum logic [1:0] {
        RK_NONE,
        RK_HIT_OK,
        RK_HIT_BAD,
        RK_ORPHAN
    } rslv_kind_t;

    function automatic int entry_w(input int addr_w, input int hist_w);
        return 2 * addr_w + hist_w + 2;
    endfunction

endpackage

// File: rtl/pdt_track_fifo.sv
// In-order tracking FIFO for issued predictions; registered count, combinational head read.
// Latency: a push is visible at the head the cycle after it is written; push is ignored when full, flush wins over push/pop.
module pdt_track_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count == CW'(DEPTH));
    assign wr_en    = push && !full && !flush;
    assign rd_en    = pop && (count != '0) && !flush;
    assign head_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/pdt_resolve.sv
// Tracks in-flight branch predictions, grades them at resolve, trains the predictor and redirects on mispredict.
// Latency 1 cycle from a resolve; backpressure: pdt_ready low when DEPTH entries are in flight, refused pushes are dropped.
module pdt_resolve
    import pdt_resolve_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pdt_valid,
    input  logic [ADDR_W-1:0]          pdt_pc_i,
    input  logic                       pdt_res_i,
    input  logic [ADDR_W-1:0]          pdt_target_i,
    input  logic                       which_pdt_i,
    input  logic [HIST_W-1:0]          history_i,
    output logic                       pdt_ready,
    input  logic                       rslv_valid,
    input  logic [ADDR_W-1:0]          rslv_pc,
    input  logic                       rslv_taken,
    input  logic [ADDR_W-1:0]          rslv_target,
    output logic                       upd_valid,
    output logic [ADDR_W-1:0]          upd_pc,
    output logic                       upd_correct,
    output logic                       upd_taken,
    output logic                       upd_which,
    output logic [HIST_W-1:0]          upd_history,
    output logic                       redirect_valid,
    output logic [ADDR_W-1:0]          redirect_pc,
    output logic                       flush,
    output logic [HIST_W-1:0]          hist_repair,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stat_branches,
    output logic [CNT_W-1:0]           stat_mispredicts
);

    localparam int ENT_W = entry_w(ADDR_W, HIST_W);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pdt_res;
        logic [ADDR_W-1:0] target;
        logic              which;
        logic [HIST_W-1:0] history;
    } entry_t;

    entry_t            push_ent;
    entry_t            head_ent;
    logic [ENT_W-1:0]  head_raw;
    logic              fifo_full;
    logic              rslv_ok;
    logic              head_hit;
    logic              pred_ok;
    logic              mispredict;
    logic              push;
    logic              pop;
    logic              graded;
    logic [ADDR_W-1:0] next_pc;
    logic [HIST_W-1:0] hist;
    rslv_kind_t        kind;

    assign push_ent = '{pc:      pdt_pc_i,
                        pdt_res: pdt_res_i,
                        target:  pdt_target_i,
                        which:   which_pdt_i,
                        history: history_i};
    assign head_ent = entry_t'(head_raw);

    // Anything resolving during a redirect cycle belongs to the squashed path.
    assign rslv_ok  = rslv_valid && !redirect_valid;
    assign head_hit = (occupancy != '0) && (head_ent.pc == rslv_pc);
    assign pred_ok  = (rslv_taken == head_ent.pdt_res) &&
                      (!rslv_taken || (rslv_target == head_ent.target));
    assign next_pc  = rslv_taken ? rslv_target : rslv_pc + ADDR_W'(PC_STEP);

    always_comb begin
        kind = RK_NONE;
        if (rslv_ok) begin
            if (!head_hit)    kind = RK_ORPHAN;
            else if (pred_ok) kind = RK_HIT_OK;
            else              kind = RK_HIT_BAD;
        end
    end

    assign mispredict = (kind == RK_HIT_BAD) || (kind == RK_ORPHAN);
    assign graded     = (kind == RK_HIT_OK) || (kind == RK_HIT_BAD);
    assign pop        = (kind == RK_HIT_OK);
    assign pdt_ready  = !fifo_full;
    assign push       = pdt_valid && pdt_ready && !redirect_valid && !mispredict;

    pdt_track_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (mispredict),
        .full     (fifo_full),
        .count    (occupancy),
        .head_dat (head_raw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid        <= 1'b0;
            upd_pc           <= '0;
            upd_correct      <= 1'b0;
            upd_taken        <= 1'b0;
            upd_which        <= 1'b0;
            upd_history      <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            hist             <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            upd_valid      <= graded;
            redirect_valid <= mispredict;
            if (graded) begin
                upd_pc      <= rslv_pc;
                upd_correct <= pred_ok;
                upd_taken   <= rslv_taken;
                upd_which   <= head_ent.which;
                upd_history <= head_ent.history;
            end
            if (mispredict) begin
                redirect_pc      <= next_pc;
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
            if (rslv_ok) begin
                hist          <= {hist[HIST_W-2:0], rslv_taken};
                stat_branches <= stat_branches + CNT_W'(1);
            end
        end
    end

    assign flush       = redirect_valid;
    assign hist_repair = hist;

endmodule

// File: tb/tb_pdt_resolve.sv
// Table-driven bench for pdt_resolve: each row is one input cycle plus the outputs expected one cycle later.
module tb_pdt_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdt_valid;
    logic [31:0] pdt_pc_i;
    logic        pdt_res_i;
    logic [31:0] pdt_target_i;
    logic        which_pdt_i;
    logic [9:0]  history_i;
    logic        pdt_ready;
    logic        rslv_valid;
    logic [31:0] rslv_pc;
    logic        rslv_taken;
    logic [31:0] rslv_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_correct;
    logic        upd_taken;
    logic        upd_which;
    logic [9:0]  upd_history;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [9:0]  hist_repair;
    logic [2:0]  occupancy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pdt_resolve #(.DEPTH(4), .ADDR_W(32), .HIST_W(10), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pdt_valid        (pdt_valid),
        .pdt_pc_i         (pdt_pc_i),
        .pdt_res_i        (pdt_res_i),
        .pdt_target_i     (pdt_target_i),
        .which_pdt_i      (which_pdt_i),
        .history_i        (history_i),
        .pdt_ready        (pdt_ready),
        .rslv_valid       (rslv_valid),
        .rslv_pc          (rslv_pc),
        .rslv_taken       (rslv_taken),
        .rslv_target      (rslv_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_correct      (upd_correct),
        .upd_taken        (upd_taken),
        .upd_which        (upd_which),
        .upd_history      (upd_history),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .hist_repair      (hist_repair),
        .occupancy        (occupancy),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pres;
        logic [31:0] ptgt;
        logic        pw;
        logic [9:0]  ph;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        e_upd;
        logic        e_cor;
        logic        e_which;
        logic [9:0]  e_uh;
        logic        e_red;
        logic [31:0] e_rpc;
        int          e_occ;
        logic [9:0]  e_hist;
        int          e_br;
        int          e_mp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(
        input logic pv, input logic [31:0] ppc, input logic pres, input logic [31:0] ptgt,
        input logic pw, input logic [9:0] ph,
        input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
        input logic e_upd, input logic e_cor, input logic e_which, input logic [9:0] e_uh,
        input logic e_red, input logic [31:0] e_rpc,
        input int e_occ, input logic [9:0] e_hist, input int e_br, input int e_mp);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pres = pres; v.ptgt = ptgt; v.pw = pw; v.ph = ph;
        v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt;
        v.e_upd = e_upd; v.e_cor = e_cor; v.e_which = e_which; v.e_uh = e_uh;
        v.e_red = e_red; v.e_rpc = e_rpc;
        v.e_occ = e_occ; v.e_hist = e_hist; v.e_br = e_br; v.e_mp = e_mp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pdt_valid    = v.pv;
        pdt_pc_i     = v.ppc;
        pdt_res_i    = v.pres;
        pdt_target_i = v.ptgt;
        which_pdt_i  = v.pw;
        history_i    = v.ph;
        rslv_valid   = v.rv;
        rslv_pc      = v.rpc;
        rslv_taken   = v.rt;
        rslv_target  = v.rtgt;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_row(input int i, input vec_t e);
        chk($sformatf("r%0d upd_valid", i), upd_valid, e.e_upd);
        if (e.e_upd) begin
            chk($sformatf("r%0d upd_pc", i), upd_pc, e.rpc);
            chk($sformatf("r%0d upd_correct", i), upd_correct, e.e_cor);
            chk($sformatf("r%0d upd_taken", i), upd_taken, e.rt);
            chk($sformatf("r%0d upd_which", i), upd_which, e.e_which);
            chk($sformatf("r%0d upd_history", i), upd_history, e.e_uh);
        end
        chk($sformatf("r%0d redirect_valid", i), redirect_valid, e.e_red);
        chk($sformatf("r%0d flush", i), flush, e.e_red);
        if (e.e_red) chk($sformatf("r%0d redirect_pc", i), redirect_pc, e.e_rpc);
        chk($sformatf("r%0d occupancy", i), occupancy, e.e_occ);
        chk($sformatf("r%0d pdt_ready", i), pdt_ready, (e.e_occ < 4));
        chk($sformatf("r%0d hist_repair", i), hist_repair, e.e_hist);
        chk($sformatf("r%0d stat_branches", i), stat_branches, e.e_br);
        chk($sformatf("r%0d stat_mispredicts", i), stat_mispredicts, e.e_mp);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " upd_valid"}, upd_valid, 0);
        chk({tag, " upd_pc"}, upd_pc, 0);
        chk({tag, " redirect_valid"}, redirect_valid, 0);
        chk({tag, " flush"}, flush, 0);
        chk({tag, " redirect_pc"}, redirect_pc, 0);
        chk({tag, " occupancy"}, occupancy, 0);
        chk({tag, " pdt_ready"}, pdt_ready, 1);
        chk({tag, " hist_repair"}, hist_repair, 0);
        chk({tag, " stat_branches"}, stat_branches, 0);
        chk({tag, " stat_mispredicts"}, stat_mispredicts, 0);
    endtask

    initial begin
        //          pv ppc        pres ptgt     pw ph       rv rpc           rt rtgt      upd cor wh uh       red rpc      occ hist    br  mp
        vecs.push_back(mk(1, 'h100, 1, 'h0F0, 1, 'h155,  0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       1, 'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h100, 1, 'h0F0,       1, 1, 1, 'h155,   0, 0,       0, 'h001, 1, 0));
        vecs.push_back(mk(1, 'h200, 1, 'h240, 0, 'h0AA,  0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       1, 'h001, 1, 0));
        vecs.push_back(mk(1, 'h204, 0, 0, 1, 'h011,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       2, 'h001, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h200, 0, 'h240,       1, 0, 0, 'h0AA,   1, 'h204,   0, 'h002, 2, 1));
        vecs.push_back(mk(1, 'h500, 0, 0, 0, 0,          1, 'h500, 1, 'h600,       0, 0, 0, 0,       0, 0,       0, 'h002, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h300, 0, 0,           0, 0, 0, 0,       1, 'h304,   0, 'h004, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       0, 'h004, 3, 2));
        vecs.push_back(mk(1, 'h400, 0, 0, 0, 'h001,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       1, 'h004, 3, 2));
        vecs.push_back(mk(1, 'h410, 0, 0, 0, 'h002,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       2, 'h004, 3, 2));
        vecs.push_back(mk(1, 'h420, 0, 0, 0, 'h003,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       3, 'h004, 3, 2));
        vecs.push_back(mk(1, 'h430, 0, 0, 0, 'h004,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       4, 'h004, 3, 2));
        vecs.push_back(mk(1, 'h440, 0, 0, 0, 'h00F,      0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       4, 'h004, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h400, 0, 0,           1, 1, 0, 'h001,   0, 0,       3, 'h008, 4, 2));
        vecs.push_back(mk(1, 'h450, 0, 0, 0, 'h005,      1, 'h410, 0, 0,           1, 1, 0, 'h002,   0, 0,       3, 'h010, 5, 2));
        vecs.push_back(mk(1, 'h460, 0, 0, 0, 'h006,      1, 'h420, 0, 0,           1, 1, 0, 'h003,   0, 0,       3, 'h020, 6, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h430, 0, 0,           1, 1, 0, 'h004,   0, 0,       2, 'h040, 7, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h450, 0, 0,           1, 1, 0, 'h005,   0, 0,       1, 'h080, 8, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h460, 1, 'h800,       1, 0, 0, 'h006,   1, 'h800,   0, 'h101, 9, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       0, 'h101, 9, 3));
        vecs.push_back(mk(1, 'h700, 1, 'h780, 1, 'h3FF,  0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       1, 'h101, 9, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'h700, 1, 'h790,       1, 0, 1, 'h3FF,   1, 'h790,   0, 'h203, 10, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       0, 'h203, 10, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 'hFFFF_FFFC, 0, 0,     0, 0, 0, 0,       1, 'h000,   0, 'h006, 11, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0, 0,               0, 0, 0, 0,       0, 0,       0, 'h006, 11, 5));

        rst = 1'b0;
        idle_inputs();
        #2;
        check_reset_state("power-on");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL r%0d scoreboard: got empty queue, expected one entry", i);
            end else begin
                check_row(i, sb_q.pop_front());
            end
        end

        // Reset asserted while a redirect is in flight.
        drive(mk(1, 'h900, 1, 'h940, 0, 'h0C3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 'h900, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("midrst pre redirect_valid", redirect_valid, 1);
        chk("midrst pre redirect_pc", redirect_pc, 'h904);
        #1;
        rst = 1'b0;
        idle_inputs();
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("postrst%0d upd_valid", k), upd_valid, 0);
            chk($sformatf("postrst%0d redirect_valid", k), redirect_valid, 0);
            chk($sformatf("postrst%0d occupancy", k), occupancy, 0);
            chk($sformatf("postrst%0d stat_branches", k), stat_branches, 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/pdt_resolve.md
Name: pdt_resolve

Overview:
- Resolution and feedback end of the branch-prediction loop; one instance per core.
- Records each prediction the predictor issues at IF in an in-order tracking FIFO and pops it when the branch resolves downstream.
- Compares predicted against actual outcome, returns a training update to the predictor, and redirects/flushes the front end on a mispredict.

Parameters:
DEPTH, 4, in-flight prediction entries (power of two, >=2)
ADDR_W, 32, instruction address width (matches InstAddrBus)
HIST_W, 10, global history width
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pdt_valid  in  1  predictor issued a prediction this cycle
pdt_pc_i  in  ADDR_W  PC of the predicted branch
pdt_res_i  in  1  predicted taken
pdt_target_i  in  ADDR_W  predicted next PC
which_pdt_i  in  1  0 = local table, 1 = global table
history_i  in  HIST_W  history used for the prediction
pdt_ready  out  1  FIFO can accept a push
rslv_valid  in  1  a branch resolved this cycle
rslv_pc  in  ADDR_W  resolved branch PC
rslv_taken  in  1  actual direction
rslv_target  in  ADDR_W  actual taken target
upd_valid  out  1  one-cycle training pulse to predictor
upd_pc  out  ADDR_W
upd_correct  out  1
upd_taken  out  1
upd_which  out  1
upd_history  out  HIST_W
redirect_valid  out  1  one-cycle pulse to pc_reg
redirect_pc  out  ADDR_W
flush  out  1  kill wrong-path IF/ID contents; equals redirect_valid
hist_repair  out  HIST_W  committed history; predictor reloads it on redirect_valid
occupancy  out  clog2(DEPTH+1)  valid entries
stat_branches  out  CNT_W  resolved branches, wrapping
stat_mispredicts  out  CNT_W  mispredicts incl. orphans, wrapping

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, committed history 0, counters 0, all registered outputs 0; pdt_ready = 1.
- pdt_ready = (occupancy < DEPTH), derived from state only; a same-cycle pop does not raise it.
- Push accepted iff pdt_valid && pdt_ready && !redirect_valid && !(mispredict or orphan detected this cycle). Otherwise dropped silently.
- rslv_valid is ignored while redirect_valid = 1, because it is a wrong-path result.
- Head match: occupancy > 0 and head.pc == rslv_pc. On a match, pop the head.
- correct = (rslv_taken == head.pdt_res) && (!rslv_taken || rslv_target == head.target).
- Actual next PC = rslv_taken ? rslv_target : rslv_pc + 4, computed mod 2^ADDR_W.
- All outputs are registered; latency is 1 cycle from a rslv_valid sample.
- Matched resolve:
  - upd_valid = 1, with upd_pc, upd_taken and upd_correct; upd_which and upd_history come from the head entry.
  - stat_branches +1.
  - If !correct: redirect_valid = flush = 1, redirect_pc = actual next PC, stat_mispredicts +1, and the whole FIFO clears on the same edge.
- Orphan (empty, or PC mismatch):
  - No upd_valid.
  - Always redirect to the actual next PC and clear the FIFO.
  - Both counters +1.
- Committed history updates on every accepted resolve: hist <= {hist[HIST_W-2:0], rslv_taken}. hist_repair shows the updated value in the same cycle as upd_valid/redirect_valid.
- Simultaneous push and correct pop: occupancy is unchanged; the pointers wrap modulo DEPTH.
- Pulses last exactly one cycle, and back-to-back correct resolves produce back-to-back upd_valid pulses.
- Reset asserted mid-operation (including an in-flight redirect) clears everything immediately; no pulse is emitted after deassertion.

Decomposition:
- Shared defines: ADDR_W/HIST_W defaults, PC step constant 4, opcode constant 7'b1100011, entry field layout {pc, pdt_res, target, which, history}.
- One sub-module, pdt_track_fifo: synchronous FIFO with push, pop, flush, full/count and a head read port. It uses the same clk/rst.

Test Plan:
- Reset: drive rst low mid-stream -> all outputs 0, occupancy 0, pdt_ready 1, counters 0.
- Correct taken: push pc 0x100, res 1, target 0x0F0, which 1, hist 0x155; resolve 0x100 taken to 0x0F0 -> next cycle upd_valid 1, correct 1, which 1, history 0x155, no redirect; stats 1/0.
- Mispredict: push 0x200 (res 1, target 0x240), then push 0x204; resolve 0x200 not-taken -> redirect_valid/flush 1, redirect_pc 0x204, upd_correct 0, occupancy 0, hist_repair LSB 0.
- Full/concurrency: 4 pushes -> pdt_ready 0 and a 5th push is dropped. With 3 entries, push plus correct resolve in the same cycle -> occupancy stays 3 and order is preserved across pointer wrap.
- Orphan: empty FIFO, resolve 0x300 not-taken -> no upd_valid, redirect_pc 0x304, stat_mispredicts +1.
- Wrong-path suppression: push and resolve presented in the redirect_valid cycle -> both ignored, occupancy 0.
